// File: rtl/ring_meter_sequencer.sv
// Ring-oscillator measurement sequencer.
// Sweeps the channels selected in channel_mask_i, one at a time, lowest index first. For each
// channel it enables the ring, waits a settle period, then runs `repeats` back-to-back
// integration windows. Each window counts synchronized rising edges of the ring tap. The
// per-channel sum, min and max window counts are offered on a valid/ready result port.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i, abort_i       begin a sweep (idle only) / cancel the sweep
//   channel_mask_i, integration_time_i, settle_time_i, repeats_i
//                          sweep configuration, latched on start
//   ring_in_i              asynchronous ring taps (already divided by 2)
//   ring_enable_o          one-hot-or-zero ring run enable
//   busy_o, done_o         sweep in progress / one-cycle completion pulse
//   result_*               per-channel result, held until result_valid_o & result_ready_i
module ring_meter_sequencer #(
   parameter int unsigned NUM_CHANNELS      = 4,
   parameter int unsigned TIME_COUNTER_BITS = 32,
   parameter int unsigned COUNT_BITS        = 32,
   parameter int unsigned REPEAT_BITS       = 4,
   localparam int unsigned SUM_BITS = COUNT_BITS + REPEAT_BITS,
   localparam int unsigned CH_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [NUM_CHANNELS-1:0]      channel_mask_i,
   input  logic [TIME_COUNTER_BITS-1:0] integration_time_i,
   input  logic [7:0]                   settle_time_i,
   input  logic [REPEAT_BITS-1:0]       repeats_i,
   input  logic [NUM_CHANNELS-1:0]      ring_in_i,
   output logic [NUM_CHANNELS-1:0]      ring_enable_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         result_valid_o,
   input  logic                         result_ready_i,
   output logic [CH_BITS-1:0]           result_channel_o,
   output logic [SUM_BITS-1:0]          result_sum_o,
   output logic [COUNT_BITS-1:0]        result_min_o,
   output logic [COUNT_BITS-1:0]        result_max_o,
   output logic                         result_overflow_o
);

   typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StReport, StDone} state_e;
   state_e state_q, state_d;

   // Edge detection: two synchronizer flops plus a history flop per ring.
   logic [NUM_CHANNELS-1:0] sync1_q, sync2_q, hist_q, ring_edge;
   assign ring_edge = sync2_q & ~hist_q;

   // Latched configuration; zero time/repeat values are stored already clamped to one.
   logic [NUM_CHANNELS-1:0]      mask_q, mask_d;
   logic [TIME_COUNTER_BITS-1:0] int_q, int_d;
   logic [7:0]                   settle_q, settle_d;
   logic [REPEAT_BITS-1:0]       rep_q, rep_d;

   logic [CH_BITS-1:0]           ch_q, ch_d;
   logic [7:0]                   settle_cnt_q, settle_cnt_d;
   logic [TIME_COUNTER_BITS-1:0] win_timer_q, win_timer_d;
   logic [REPEAT_BITS-1:0]       rep_cnt_q, rep_cnt_d;
   logic [COUNT_BITS-1:0]        win_cnt_q, win_cnt_d;
   logic [SUM_BITS-1:0]          sum_q, sum_d;
   logic [COUNT_BITS-1:0]        min_q, min_d, max_q, max_d;
   logic                         ovf_q, ovf_d;

   logic [CH_BITS-1:0]           res_ch_q, res_ch_d;
   logic [SUM_BITS-1:0]          res_sum_q, res_sum_d;
   logic [COUNT_BITS-1:0]        res_min_q, res_min_d, res_max_q, res_max_d;
   logic                         res_ovf_q, res_ovf_d;

   // Channel selection: lowest set bit of the incoming mask, and next set bit above ch_q.
   logic [CH_BITS-1:0] first_ch, next_ch;
   logic               first_found, next_found;

   always_comb begin
      first_ch    = '0;
      first_found = 1'b0;
      next_ch     = '0;
      next_found  = 1'b0;
      for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
         if (channel_mask_i[i] && !first_found) begin
            first_found = 1'b1;
            first_ch    = CH_BITS'(i);
         end
         if (mask_q[i] && (i > int'(ch_q)) && !next_found) begin
            next_found = 1'b1;
            next_ch    = CH_BITS'(i);
         end
      end
   end

   // Window arithmetic for the current cycle, including an edge arriving this cycle.
   logic                  edge_cur, cnt_sat, win_end, rep_last, ovf_now;
   logic [COUNT_BITS-1:0] cnt_now, min_now, max_now;
   logic [SUM_BITS-1:0]   sum_now;
   logic [7:0]            settle_in_eff;

   assign edge_cur      = ring_edge[ch_q];
   assign cnt_sat       = &win_cnt_q;
   assign cnt_now       = (edge_cur && !cnt_sat) ? win_cnt_q + COUNT_BITS'(1) : win_cnt_q;
   assign ovf_now       = ovf_q | (edge_cur & cnt_sat);
   assign sum_now       = sum_q + SUM_BITS'(cnt_now);
   assign min_now       = (cnt_now < min_q) ? cnt_now : min_q;
   assign max_now       = (cnt_now > max_q) ? cnt_now : max_q;
   assign win_end       = (win_timer_q == int_q - TIME_COUNTER_BITS'(1));
   assign rep_last      = (rep_cnt_q == rep_q - REPEAT_BITS'(1));
   assign settle_in_eff = (settle_time_i == 8'd0) ? 8'd1 : settle_time_i;

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start_i) state_d = (channel_mask_i == '0) ? StDone : StSettle;
         StSettle:  if (settle_cnt_q == 8'd0) state_d = StMeasure;
         StMeasure: if (win_end && rep_last) state_d = StReport;
         StReport:  if (result_ready_i) state_d = next_found ? StSettle : StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      // Abort wins over everything, including a handshake in the same cycle.
      if (abort_i && (state_q != StIdle)) state_d = StIdle;
   end

   // FSM outputs.
   always_comb begin
      ring_enable_o  = '0;
      busy_o         = 1'b0;
      done_o         = 1'b0;
      result_valid_o = 1'b0;
      unique case (state_q)
         StSettle, StMeasure: begin
            ring_enable_o[ch_q] = 1'b1;
            busy_o              = 1'b1;
         end
         StReport: begin
            busy_o         = 1'b1;
            result_valid_o = 1'b1;
         end
         StDone:  done_o = 1'b1;
         default: ;
      endcase
   end

   // Datapath next state.
   always_comb begin
      mask_d = mask_q; int_d = int_q; settle_d = settle_q; rep_d = rep_q;
      ch_d = ch_q; settle_cnt_d = settle_cnt_q; win_timer_d = win_timer_q;
      rep_cnt_d = rep_cnt_q; win_cnt_d = win_cnt_q;
      sum_d = sum_q; min_d = min_q; max_d = max_q; ovf_d = ovf_q;
      res_ch_d = res_ch_q; res_sum_d = res_sum_q; res_min_d = res_min_q;
      res_max_d = res_max_q; res_ovf_d = res_ovf_q;
      unique case (state_q)
         StIdle: if (start_i) begin
            mask_d       = channel_mask_i;
            int_d        = (integration_time_i == '0) ? TIME_COUNTER_BITS'(1) : integration_time_i;
            settle_d     = settle_in_eff;
            rep_d        = (repeats_i == '0) ? REPEAT_BITS'(1) : repeats_i;
            ch_d         = first_ch;
            settle_cnt_d = settle_in_eff - 8'd1;
         end
         StSettle: begin
            if (settle_cnt_q == 8'd0) begin
               win_timer_d = '0;
               rep_cnt_d   = '0;
               win_cnt_d   = '0;
               sum_d       = '0;
               min_d       = '1;
               max_d       = '0;
               ovf_d       = 1'b0;
            end else begin
               settle_cnt_d = settle_cnt_q - 8'd1;
            end
         end
         StMeasure: begin
            ovf_d = ovf_now;
            if (win_end) begin
               // Windows abut: the next window starts counting on the following cycle.
               win_timer_d = '0;
               win_cnt_d   = '0;
               sum_d       = sum_now;
               min_d       = min_now;
               max_d       = max_now;
               rep_cnt_d   = rep_cnt_q + REPEAT_BITS'(1);
               if (rep_last) begin
                  res_ch_d  = ch_q;
                  res_sum_d = sum_now;
                  res_min_d = min_now;
                  res_max_d = max_now;
                  res_ovf_d = ovf_now;
               end
            end else begin
               win_timer_d = win_timer_q + TIME_COUNTER_BITS'(1);
               win_cnt_d   = cnt_now;
            end
         end
         StReport: if (result_ready_i && next_found) begin
            ch_d         = next_ch;
            settle_cnt_d = settle_q - 8'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0; sync2_q <= '0; hist_q <= '0;
         mask_q <= '0; int_q <= '0; settle_q <= '0; rep_q <= '0;
         ch_q <= '0; settle_cnt_q <= '0; win_timer_q <= '0; rep_cnt_q <= '0;
         win_cnt_q <= '0; sum_q <= '0; min_q <= '0; max_q <= '0; ovf_q <= 1'b0;
         res_ch_q <= '0; res_sum_q <= '0; res_min_q <= '0; res_max_q <= '0;
         res_ovf_q <= 1'b0;
      end else begin
         sync1_q <= ring_in_i; sync2_q <= sync1_q; hist_q <= sync2_q;
         mask_q <= mask_d; int_q <= int_d; settle_q <= settle_d; rep_q <= rep_d;
         ch_q <= ch_d; settle_cnt_q <= settle_cnt_d; win_timer_q <= win_timer_d;
         rep_cnt_q <= rep_cnt_d; win_cnt_q <= win_cnt_d;
         sum_q <= sum_d; min_q <= min_d; max_q <= max_d; ovf_q <= ovf_d;
         res_ch_q <= res_ch_d; res_sum_q <= res_sum_d; res_min_q <= res_min_d;
         res_max_q <= res_max_d; res_ovf_q <= res_ovf_d;
      end
   end

   assign result_channel_o  = res_ch_q;
   assign result_sum_o      = res_sum_q;
   assign result_min_o      = res_min_q;
   assign result_max_o      = res_max_q;
   assign result_overflow_o = res_ovf_q;

endmodule

// File: tb/tb_ring_meter_sequencer.sv
// Randomized bench for ring_meter_sequencer. Ring taps are periodic square waves with known
// rise times; expected window counts come from counting those rises (shifted by the two-cycle
// detection latency) inside each window's cycle range, derived from start/handshake times.
module tb_ring_meter_sequencer;
   localparam int unsigned NCH = 4;
   localparam int unsigned TBITS = 16;
   localparam int unsigned CB = 4;
   localparam int unsigned RB = 4;
   localparam int unsigned SB = CB + RB;
   localparam int unsigned CHB = 2;
   localparam int CMAX = (1 << CB) - 1;

   logic             clk = 1'b0;
   logic             rst_n, start, abort, result_ready;
   logic [NCH-1:0]   channel_mask, ring_in, ring_enable;
   logic [TBITS-1:0] integration_time;
   logic [7:0]       settle_time;
   logic [RB-1:0]    repeats;
   logic             busy, done, result_valid, result_overflow;
   logic [CHB-1:0]   result_channel;
   logic [SB-1:0]    result_sum;
   logic [CB-1:0]    result_min, result_max;

   always #5 clk = ~clk;

   ring_meter_sequencer #(
      .NUM_CHANNELS(NCH), .TIME_COUNTER_BITS(TBITS), .COUNT_BITS(CB), .REPEAT_BITS(RB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .channel_mask_i(channel_mask), .integration_time_i(integration_time),
      .settle_time_i(settle_time), .repeats_i(repeats), .ring_in_i(ring_in),
      .ring_enable_o(ring_enable), .busy_o(busy), .done_o(done),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_channel_o(result_channel), .result_sum_o(result_sum),
      .result_min_o(result_min), .result_max_o(result_max),
      .result_overflow_o(result_overflow)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int period[NCH];
   int phase[NCH];
   // Expected ring_enable: channel en_ch high during cycles [en_from, en_to).
   int en_ch = 0, en_from = 0, en_to = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic tap(input int ch, input int k);
      return ((k + phase[ch]) % period[ch]) < (period[ch] / 2);
   endfunction

   // Edges visible to the counter in cycles [a, b): input rises two cycles earlier.
   function automatic int rises(input int ch, input int a, input int b);
      int n = 0;
      for (int r = a - 2; r < b - 2; r++) if (((r + phase[ch]) % period[ch]) == 0) n++;
      return n;
   endfunction

   function automatic int first_set(input logic [NCH-1:0] m, input int after);
      for (int i = 0; i < NCH; i++) if (m[i] && i > after) return i;
      return -1;
   endfunction

   task automatic tick();
      logic [NCH-1:0] exp_en;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NCH; i++) ring_in[i] = tap(i, cyc);
      exp_en = '0;
      if (cyc >= en_from && cyc < en_to) exp_en[en_ch] = 1'b1;
      check_eq("ring_enable", 64'(ring_enable), 64'(exp_en));
   endtask

   task automatic scramble();
      channel_mask     = NCH'($urandom);
      integration_time = TBITS'($urandom);
      settle_time      = 8'($urandom);
      repeats          = RB'($urandom);
   endtask

   task automatic run_sweep(input logic [NCH-1:0] mask, input int t_int, input int t_set,
                            input int reps, input int bp_max);
      int te, se, re, t, m0, rep_at, ch, last_ch, n, sum, mn, mx, ovf, d;
      te = (t_int == 0) ? 1 : t_int;
      se = (t_set == 0) ? 1 : t_set;
      re = (reps == 0) ? 1 : reps;
      channel_mask = mask; integration_time = TBITS'(t_int);
      settle_time = 8'(t_set); repeats = RB'(reps);
      ch = first_set(mask, -1);
      last_ch = ch;
      sum = 0;
      start = 1'b1;
      t = cyc;
      if (ch >= 0) begin en_ch = ch; en_from = t + 1; en_to = t + 1 + se + re * te; end
      tick();
      start = 1'b0;
      scramble();
      if (ch < 0) begin
         check_eq("empty_done", 64'(done), 1);
         check_eq("empty_busy", 64'(busy), 0);
         check_eq("empty_valid", 64'(result_valid), 0);
         tick();
         check_eq("empty_done_clr", 64'(done), 0);
         check_eq("empty_valid2", 64'(result_valid), 0);
         return;
      end
      check_eq("busy_start", 64'(busy), 1);
      while (ch >= 0) begin
         m0 = t + 1 + se;
         rep_at = m0 + re * te;
         while (!result_valid && cyc < rep_at + 4) tick();
         check_eq("valid_cycle", 64'(cyc), 64'(rep_at));
         sum = 0; mn = CMAX; mx = 0; ovf = 0;
         for (int w = 0; w < re; w++) begin
            n = rises(ch, m0 + w * te, m0 + (w + 1) * te);
            if (n > CMAX) begin ovf = 1; n = CMAX; end
            sum += n;
            if (n < mn) mn = n;
            if (n > mx) mx = n;
         end
         check_eq("res_channel", 64'(result_channel), 64'(ch));
         check_eq("res_sum", 64'(result_sum), 64'(sum));
         check_eq("res_min", 64'(result_min), 64'(mn));
         check_eq("res_max", 64'(result_max), 64'(mx));
         check_eq("res_ovf", 64'(result_overflow), 64'(ovf));
         check_eq("busy_report", 64'(busy), 1);
         d = $urandom_range(bp_max, 0);
         repeat (d) begin
            start = 1'($urandom_range(1, 0));
            tick();
            check_eq("bp_valid", 64'(result_valid), 1);
            check_eq("bp_sum", 64'(result_sum), 64'(sum));
            check_eq("bp_min", 64'(result_min), 64'(mn));
         end
         start = 1'b0;
         result_ready = 1'b1;
         last_ch = ch;
         ch = first_set(mask, ch);
         t = cyc;
         if (ch >= 0) begin en_ch = ch; en_from = t + 1; en_to = t + 1 + se + re * te; end
         tick();
         result_ready = 1'b0;
         check_eq("valid_drop", 64'(result_valid), 0);
      end
      check_eq("done_pulse", 64'(done), 1);
      check_eq("done_busy", 64'(busy), 0);
      check_eq("done_hold_ch", 64'(result_channel), 64'(last_ch));
      check_eq("done_hold_sum", 64'(result_sum), 64'(sum));
      tick();
      check_eq("done_clr", 64'(done), 0);
      check_eq("idle_busy", 64'(busy), 0);
   endtask

   task automatic abort_test(input bit in_report);
      int t, rep_at;
      channel_mask = 4'b0110; integration_time = 40; settle_time = 3; repeats = 2;
      start = 1'b1;
      t = cyc;
      rep_at = t + 1 + 3 + 80;
      en_ch = 1; en_from = t + 1; en_to = rep_at;
      tick();
      start = 1'b0;
      if (!in_report) begin
         repeat ($urandom_range(60, 10)) tick();
      end else begin
         while (!result_valid && cyc < rep_at + 4) tick();
         check_eq("abort_pre_valid", 64'(result_valid), 1);
         result_ready = 1'b1;
      end
      abort = 1'b1;
      en_to = cyc + 1;
      tick();
      abort = 1'b0;
      result_ready = 1'b0;
      check_eq("abort_valid", 64'(result_valid), 0);
      check_eq("abort_busy", 64'(busy), 0);
      check_eq("abort_done", 64'(done), 0);
      tick();
      check_eq("abort_done2", 64'(done), 0);
      check_eq("abort_busy2", 64'(busy), 0);
   endtask

   task automatic reset_test();
      int t, rep_at;
      channel_mask = 4'b0001; integration_time = 100; settle_time = 2; repeats = 1;
      start = 1'b1;
      t = cyc;
      rep_at = t + 1 + 2 + 100;
      en_ch = 0; en_from = t + 1; en_to = rep_at;
      tick();
      start = 1'b0;
      while (!result_valid && cyc < rep_at + 4) tick();
      check_eq("rst_pre_valid", 64'(result_valid), 1);
      #1 rst_n = 1'b0;
      en_to = 0;
      #1;
      check_eq("rst_valid", 64'(result_valid), 0);
      check_eq("rst_busy", 64'(busy), 0);
      check_eq("rst_en", 64'(ring_enable), 0);
      check_eq("rst_sum", 64'(result_sum), 0);
      check_eq("rst_max", 64'(result_max), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (6) tick();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
      channel_mask = '0; integration_time = '0; settle_time = '0; repeats = '0;
      ring_in = '0;
      period[0] = 8;
      for (int i = 1; i < NCH; i++) period[i] = $urandom_range(30, 8);
      for (int i = 0; i < NCH; i++) phase[i] = $urandom_range(period[i] - 1, 0);
      repeat (3) tick();
      check_eq("reset_busy", 64'(busy), 0);
      check_eq("reset_done", 64'(done), 0);
      check_eq("reset_valid", 64'(result_valid), 0);
      check_eq("reset_sum", 64'(result_sum), 0);
      check_eq("reset_min", 64'(result_min), 0);
      check_eq("reset_max", 64'(result_max), 0);
      check_eq("reset_ch", 64'(result_channel), 0);
      check_eq("reset_ovf", 64'(result_overflow), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      run_sweep(4'b0001, 100, 4, 1, 0);
      run_sweep(4'b1010, 60, 2, 3, 50);
      run_sweep(4'b0001, 200, 0, 2, 3);
      run_sweep(4'b0000, 10, 1, 1, 0);
      run_sweep(4'b1111, 1, 0, 0, 2);
      run_sweep(4'b0100, 0, 255, 0, 0);
      abort_test(1'b0);
      abort_test(1'b1);
      for (int k = 0; k < 10; k++) begin
         run_sweep(NCH'($urandom), $urandom_range(150, 0), $urandom_range(20, 0),
                   $urandom_range(4, 0), $urandom_range(8, 0));
         repeat ($urandom_range(3, 0)) tick();
      end
      reset_test();
      run_sweep(4'b1001, 30, 1, 2, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ring_meter_sequencer.md
Name: ring_meter_sequencer

Overview:
Multi-channel measurement sequencer for ring-oscillator instrumented blocks such as adder delay rings. It enables one ring at a time and waits a settle period. It then runs repeated integration windows counting ring edges and reports the sum, min and max count per channel over a valid/ready handshake. It replaces the single fixed integration counter with a configurable, channel-sweeping controller.

Parameters:
NUM_CHANNELS, 4, number of ring oscillators measured (>=1)
TIME_COUNTER_BITS, 32, width of integration_time
COUNT_BITS, 32, width of per-window edge counter
REPEAT_BITS, 4, width of repeats; SUM_BITS = COUNT_BITS+REPEAT_BITS; CH_BITS = max(1,$clog2(NUM_CHANNELS))

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep (sampled in IDLE only)
abort  input  1  cancel sweep, return to IDLE
channel_mask  input  NUM_CHANNELS  channels to measure, latched at start
integration_time  input  TIME_COUNTER_BITS  window length in clk cycles, latched at start
settle_time  input  8  cycles between ring enable and first window, latched at start
repeats  input  REPEAT_BITS  windows per channel, latched at start
ring_in  input  NUM_CHANNELS  asynchronous ring taps (already divided by 2)
ring_enable  output  NUM_CHANNELS  one-hot-or-zero run enable per ring (drives stop_b)
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep completion
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
result_channel  output  CH_BITS  channel index of result
result_sum  output  SUM_BITS  sum of window counts
result_min  output  COUNT_BITS  smallest window count
result_max  output  COUNT_BITS  largest window count
result_overflow  output  1  any window counter saturated

Behaviour:
- Reset (async, reset_n low): state IDLE. All outputs 0, all counters and latched config 0, synchronizers cleared.
- Each ring_in bit passes a 2-flop synchronizer plus a history flop. edge = sync & ~hist, giving 2-3 cycles detection latency. The ring tap must toggle slower than clk/4; faster input is undefined.
- States: IDLE, SETTLE, MEASURE, REPORT, DONE.
- IDLE: start=1 latches config. Mask==0 -> DONE. Otherwise SETTLE on the lowest set channel; busy=1 from the cycle after start. repeats==0 is treated as 1. integration_time==0 is treated as 1.
- SETTLE: ring_enable[ch]=1. Stays settle_time cycles (0 -> exits next cycle). Edges are ignored. Then MEASURE; window counter=0, min=all-ones, max=0, sum=0, overflow=0.
- MEASURE: ring_enable held. Each cycle with edge[ch] increments the window count, saturating at all-ones; saturation sets the overflow flag.
  - After exactly integration_time cycles the final count (including an edge in the last cycle) folds into sum/min/max.
  - Windows run back-to-back with no gap. An edge on the first cycle of the next window counts to that window.
  - After the last repeat -> REPORT.
- REPORT: ring_enable=0, result_valid=1. All result_* are stable until result_valid&result_ready.
  - On handshake: next higher set mask bit -> SETTLE, else DONE.
  - result_valid drops the cycle after the handshake. A consumer holding result_ready high costs one cycle per result.
- DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE. result_* keep the last values.
- abort=1 in any non-IDLE state: IDLE next cycle, with ring_enable=0, result_valid=0, busy=0 and no done pulse. abort takes priority over a handshake in the same cycle.
- start while not IDLE is ignored. Config inputs changing mid-sweep have no effect.
- Sum cannot overflow: 2^REPEAT_BITS-1 windows of COUNT_BITS each fit in SUM_BITS.

Test Plan:
- Single channel, mask=0001, settle=4, integration=100, repeats=1, ring_in[0] rising every 10 clk -> one result, channel 0, sum=10±1, min=max=sum, overflow=0, then done pulse, busy=0.
- Repeats=3 with ring_in[0] period changed per window (10, 20, 25 clk), integration=100 -> sum≈(10+5+4), min≈4, max≈10, all within ±1.
- Mask=1010, both rings toggling -> results for channel 1 then channel 3 in order. ring_enable is never multi-hot and is 0 during REPORT.
- Backpressure: hold result_ready=0 for 50 cycles -> result_valid and result_* constant, no ring_enable asserted. Ready=1 then advances exactly one result.
- COUNT_BITS=4, ring rising every 8 clk, integration=200 -> window count saturates at 15, overflow=1.
- Abort asserted mid-MEASURE -> IDLE next cycle, ring_enable=0, no done. Mask=0 start -> done pulse within 2 cycles and no result_valid. Reset_n low mid-REPORT -> all outputs 0 immediately.
